fifo_frame_writer: RTL and testbench

//  Write-side framing stage feeding the async FIFO (wrclk domain). Accepts a byte stream
//  (valid/ready with last), stages one frame locally, then writes a length header followed
//  by the payload into the FIFO.

---
 rtl/fifo_frame_writer.sv | 152 +++++++++++++++
 tb/tb_fifo_frame_writer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/fifo_frame_writer.sv
// Write-side framer: stages one frame, then writes a length header and payload to the async FIFO.
// Optional trailing XOR checksum byte when FRAME_CKSUM_EN is defined.
module fifo_frame_writer #(
    parameter int MAX_LEN = 16,
    parameter int CNT_W   = 8
) (
    input  logic             wrclk,
    input  logic             rst,
    input  logic [7:0]       s_data,
    input  logic             s_valid,
    input  logic             s_last,
    output logic             s_ready,
    input  logic             fifo_full,
    output logic [7:0]       fifo_wrdata,
    output logic             fifo_wren,
    output logic [CNT_W-1:0] frame_count,
    output logic             trunc_err
);
    localparam int IDX_W = $clog2(MAX_LEN);
    localparam int LEN_W = IDX_W + 1;
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

`ifdef FRAME_CKSUM_EN
    typedef enum logic [2:0] {IDLE, COLLECT, DISCARD, HEADER, DRAIN, CKSUM} state_t;
`else
    typedef enum logic [2:0] {IDLE, COLLECT, DISCARD, HEADER, DRAIN} state_t;
`endif

    state_t             state_q;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   len_d;
    logic [IDX_W-1:0]   rd_idx_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               terr_q;
    logic               trunc_q;
    logic [7:0]         mem_q [MAX_LEN];
    logic               xfer;
    logic               stage_we;
    logic [IDX_W-1:0]   wr_idx;
    logic               wr_state;
    logic               rd_last;
    logic [7:0]         wrdata;

    assign s_ready  = (state_q == IDLE) || (state_q == COLLECT)
                   || (state_q == DISCARD);
    assign xfer     = s_valid & s_ready;
    assign stage_we = xfer && ((state_q == IDLE) || (state_q == COLLECT));
    assign wr_idx   = (state_q == IDLE) ? '0 : len_q[IDX_W-1:0];
    assign len_d    = len_q + 1'b1;
    assign rd_last  = (LEN_W'(rd_idx_q) == (len_q - 1'b1));

`ifdef FRAME_CKSUM_EN
    logic [7:0] cks_q;

    always_ff @(posedge wrclk or posedge rst) begin
        if (rst) begin
            cks_q <= '0;
        end else if (stage_we) begin
            cks_q <= (state_q == IDLE) ? s_data : (cks_q ^ s_data);
        end
    end
`endif

    // Staging RAM is deliberately not reset.
    always_ff @(posedge wrclk) begin
        if (stage_we) begin
            mem_q[wr_idx] <= s_data;
        end
    end

    always_comb begin
        wr_state = 1'b0;
        wrdata   = '0;
        case (state_q)
            HEADER: begin
                wr_state = 1'b1;
                wrdata   = {trunc_q, 2'b00, 5'(len_q)};
            end
            DRAIN: begin
                wr_state = 1'b1;
                wrdata   = mem_q[rd_idx_q];
            end
`ifdef FRAME_CKSUM_EN
            CKSUM: begin
                wr_state = 1'b1;
                wrdata   = cks_q;
            end
`endif
            default: ;
        endcase
    end

    assign fifo_wren   = wr_state & ~fifo_full;
    assign fifo_wrdata = wrdata;
    assign frame_count = cnt_q;
    assign trunc_err   = terr_q;

    always_ff @(posedge wrclk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            len_q    <= '0;
            rd_idx_q <= '0;
            cnt_q    <= '0;
            terr_q   <= 1'b0;
            trunc_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (xfer) begin
                    len_q   <= LEN_W'(1);
                    state_q <= s_last ? HEADER : COLLECT;
                end
                COLLECT: if (xfer) begin
                    len_q <= len_d;
                    if (s_last) begin
                        state_q <= HEADER;
                    end else if (len_d == LEN_MAX) begin
                        trunc_q <= 1'b1;
                        terr_q  <= 1'b1;
                        state_q <= DISCARD;
                    end
                end
                DISCARD: if (xfer && s_last) begin
                    state_q <= HEADER;
                end
                HEADER: if (fifo_wren) begin
                    rd_idx_q <= '0;
                    state_q  <= DRAIN;
                end
                DRAIN: if (fifo_wren) begin
                    rd_idx_q <= rd_idx_q + 1'b1;
                    if (rd_last) begin
                        trunc_q <= 1'b0;
`ifdef FRAME_CKSUM_EN
                        state_q <= CKSUM;
`else
                        cnt_q   <= cnt_q + 1'b1;
                        state_q <= IDLE;
`endif
                    end
                end
`ifdef FRAME_CKSUM_EN
                CKSUM: if (fifo_wren) begin
                    cnt_q   <= cnt_q + 1'b1;
                    state_q <= IDLE;
                end
`endif
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_frame_writer.sv
// Self-checking bench for fifo_frame_writer: vector table plus scoreboard of FIFO writes.
// Hand-written sequences cover latency, backpressure, reset abort and count wrap.
module tb_fifo_frame_writer;
    localparam int MAXL = 16;

    logic       wrclk = 1'b0;
    logic       rst;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_last;
    logic       s_ready;
    logic       fifo_full;
    logic [7:0] fifo_wrdata;
    logic       fifo_wren;
    logic [7:0] frame_count;
    logic       trunc_err;

    int checks   = 0;
    int failures = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_cnt;

    fifo_frame_writer #(.MAX_LEN(MAXL), .CNT_W(8)) dut (
        .wrclk(wrclk), .rst(rst),
        .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
        .s_ready(s_ready), .fifo_full(fifo_full),
        .fifo_wrdata(fifo_wrdata), .fifo_wren(fifo_wren),
        .frame_count(frame_count), .trunc_err(trunc_err)
    );

    always #5 wrclk = ~wrclk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Scoreboard: every FIFO write is popped and compared.
    always @(negedge wrclk) begin
        if (!rst) begin
            if (fifo_full) chk("wren_while_full", 32'(fifo_wren), 0);
            if (fifo_wren) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_write actual=%0h required=none",
                             fifo_wrdata);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    if (fifo_wrdata !== e) begin
                        failures++;
                        $display("FAIL fifo_data actual=%0h required=%0h",
                                 fifo_wrdata, e);
                    end
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] d, input logic l);
        int n = 0;
        s_data  = d;
        s_valid = 1'b1;
        s_last  = l;
        while (!s_ready && n < 1000) begin
            @(negedge wrclk);
            n++;
        end
        if (n >= 1000) chk("s_ready_timeout", 0, 1);
        @(posedge wrclk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic push_frame(input int len, input logic [7:0] base,
                              input logic [7:0] step, input logic [7:0] hdr);
        logic [7:0] b;
        logic [7:0] x = 8'h00;
        int n;
        n = (len > MAXL) ? MAXL : len;
        exp_q.push_back(hdr);
        for (int k = 0; k < n; k++) begin
            b = base + 8'(k) * step;
            exp_q.push_back(b);
            x = x ^ b;
        end
`ifdef FRAME_CKSUM_EN
        exp_q.push_back(x);
`endif
    endtask

    task automatic send_frame(input int len, input logic [7:0] base,
                              input logic [7:0] step);
        for (int k = 0; k < len; k++)
            send_byte(base + 8'(k) * step, k == len - 1);
    endtask

    task automatic wait_drain(input string nm);
        int n = 0;
        while (!(exp_q.size() == 0 && s_ready) && n < 500) begin
            @(negedge wrclk);
            n++;
        end
        chk(nm, 32'(n < 500), 1);
    endtask

    typedef struct {
        int         len;
        logic [7:0] base;
        logic [7:0] step;
        logic [7:0] hdr;
        logic       terr;
    } vec_t;
    vec_t tbl[6];

    initial begin
        tbl[0] = '{3,  8'h11, 8'h11, 8'h03, 1'b0};
        tbl[1] = '{1,  8'h5A, 8'h00, 8'h01, 1'b0};
        tbl[2] = '{16, 8'h01, 8'h01, 8'h10, 1'b0};
        tbl[3] = '{5,  8'hF0, 8'h07, 8'h05, 1'b0};
        tbl[4] = '{20, 8'h00, 8'h01, 8'h90, 1'b1};
        tbl[5] = '{2,  8'hC0, 8'h03, 8'h02, 1'b1};

        rst = 1'b1; s_data = '0; s_valid = 0; s_last = 0; fifo_full = 0;
        exp_cnt = '0;
        #3;
        chk("rst_s_ready", 32'(s_ready), 1);
        chk("rst_wren", 32'(fifo_wren), 0);
        chk("rst_wrdata", 32'(fifo_wrdata), 0);
        chk("rst_count", 32'(frame_count), 0);
        chk("rst_trunc_err", 32'(trunc_err), 0);
        @(negedge wrclk); @(negedge wrclk);
        rst = 1'b0;

        // 11,22,33: header and payload on four back-to-back cycles.
        push_frame(3, 8'h11, 8'h11, 8'h03);
        send_frame(3, 8'h11, 8'h11);
        for (int k = 0; k < 4; k++) begin
            chk("lat_wren", 32'(fifo_wren), 1);
            chk("lat_s_ready", 32'(s_ready), 0);
            @(posedge wrclk); #1;
        end
        exp_cnt++;
        chk("lat_idle", 32'(s_ready), 1);
        chk("lat_count", 32'(frame_count), 32'(exp_cnt));
        wait_drain("lat_drain");

        for (int i = 0; i < 6; i++) begin
            push_frame(tbl[i].len, tbl[i].base, tbl[i].step, tbl[i].hdr);
            send_frame(tbl[i].len, tbl[i].base, tbl[i].step);
            wait_drain("tbl_drain");
            exp_cnt++;
            chk("tbl_count", 32'(frame_count), 32'(exp_cnt));
            chk("tbl_trunc_err", 32'(trunc_err), 32'(tbl[i].terr));
        end

        // Backpressure: full for 5 cycles from HEADER, then alternating.
        push_frame(3, 8'h11, 8'h11, 8'h03);
        send_frame(3, 8'h11, 8'h11);
        fifo_full = 1'b1;
        repeat (5) begin @(posedge wrclk); #1; end
        for (int k = 0; k < 12; k++) begin
            fifo_full = k[0];
            @(posedge wrclk); #1;
        end
        fifo_full = 1'b0;
        wait_drain("bp_drain");
        exp_cnt++;
        chk("bp_count", 32'(frame_count), 32'(exp_cnt));

        // Reset mid-DRAIN after header and AA written.
        exp_q.push_back(8'h03);
        exp_q.push_back(8'hAA);
        send_frame(3, 8'hAA, 8'h11);
        @(posedge wrclk); #1;
        @(posedge wrclk); #1;
        rst = 1'b1;
        #1;
        chk("abort_wren", 32'(fifo_wren), 0);
        chk("abort_idle", 32'(s_ready), 1);
        chk("abort_count", 32'(frame_count), 0);
        chk("abort_trunc_err", 32'(trunc_err), 0);
        chk("abort_sb_empty", 32'(exp_q.size()), 0);
        @(negedge wrclk);
        rst = 1'b0;
        exp_cnt = '0;
        repeat (6) @(negedge wrclk);

        // frame_count wraps after 256 one-byte frames.
        for (int i = 0; i < 256; i++) begin
            push_frame(1, 8'(i), 8'h00, 8'h01);
            send_frame(1, 8'(i), 8'h00);
            wait_drain("wrap_drain");
            exp_cnt++;
            if (i == 254 || i == 255)
                chk("wrap_count", 32'(frame_count), 32'(exp_cnt));
        end
        chk("wrap_zero", 32'(frame_count), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=done");
        $fatal(1, "timeout");
    end
endmodule
